uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1 framing, LSB first, idle-high line. It is the receive half of the board's UART link and is clocked by the 50 MHz system clock. It synchronizes the incoming line, detects and qualifies the start bit, samples each bit at mid-period, and presents the byte to the command logic on a ready/clear handshake. It reports framing and overrun errors.

---
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, idle-high line.
// The line is double-synchronized, the start bit is re-checked at mid-bit,
// and each data/stop bit is sampled at mid-period. The received byte is
// handed to the consumer through a rdy/clr_rdy handshake with framing and
// overrun flags. BAUD_DIV must be at least 16 and fit the 12-bit counter.
`timescale 1ns/1ps

module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  // Half a bit period lands the start-bit check in the middle of the bit;
  // a full period minus one spaces successive samples exactly BAUD_DIV apart
  // because the sample itself consumes the zero-count cycle.
  localparam logic [11:0] HALF_CNT   = 12'(BAUD_DIV / 2);
  localparam logic [11:0] RELOAD_CNT = 12'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic        s3;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shift_reg;
  logic [8:0]  shift_next;
  logic        fall_edge;
  logic        frame_done;

  // Synchronizer and edge-detect flops, preset high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= RX;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall_edge  = s3 & ~s2;
  assign shift_next = {s2, shift_reg[8:1]};
  assign frame_done = (state == DATA) && (baud_cnt == 12'd0) && (bit_cnt == 4'd8);

  // Receive FSM with counters, shift register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= 12'd0;
      bit_cnt   <= 4'd0;
      shift_reg <= 9'd0;
      rx_data   <= 8'h00;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fall_edge) begin
            baud_cnt <= HALF_CNT;
            bit_cnt  <= 4'd0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt != 12'd0) begin
            baud_cnt <= baud_cnt - 12'd1;
          end else if (s2) begin
            state <= IDLE;
          end else begin
            baud_cnt <= RELOAD_CNT;
            state    <= DATA;
          end
        end
        DATA: begin
          if (baud_cnt != 12'd0) begin
            baud_cnt <= baud_cnt - 12'd1;
          end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 4'd1;
            baud_cnt  <= RELOAD_CNT;
            if (bit_cnt == 4'd8) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // A completing frame takes priority over an acknowledge in the same cycle;
      // overrun is only flagged if the previous byte was still unacknowledged.
      if (frame_done) begin
        rx_data <= shift_next[7:0];
        frm_err <= ~shift_next[8];
        rdy     <= 1'b1;
        ovr_err <= rdy & ~clr_rdy;
      end else if (clr_rdy) begin
        rdy     <= 1'b0;
        frm_err <= 1'b0;
        ovr_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are bit-banged onto RX
// at nominal and skewed bit periods; a transaction-level model of the
// rdy/clr_rdy handshake predicts every output.
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int BAUD = 100;
  localparam int STOP_LAT = 3 + BAUD / 2 + 1 + 9 * BAUD;

  logic       clk;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  int test_count = 0;
  int fail_count = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_rdy = 1'b0;
  logic       exp_frm = 1'b0;
  logic       exp_ovr = 1'b0;

  uart_rx #(.BAUD_DIV(BAUD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr_err (ovr_err)
  );

  // 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against any hang; normal runs end long before this.
  initial begin
    #800000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare all four outputs against the model.
  task automatic checkAll(input string tag);
    checkOutput({tag, ".rx_data"}, 32'(rx_data), 32'(exp_data));
    checkOutput({tag, ".rdy"}, 32'(rdy), 32'(exp_rdy));
    checkOutput({tag, ".frm_err"}, 32'(frm_err), 32'(exp_frm));
    checkOutput({tag, ".ovr_err"}, 32'(ovr_err), 32'(exp_ovr));
  endtask

  // Model: a delivered frame always shows its byte and stop-bit status;
  // it is an overrun when the previous byte had not been acknowledged.
  task automatic modelFrame(input logic [7:0] data, input logic stop_bit);
    exp_ovr  = exp_rdy;
    exp_rdy  = 1'b1;
    exp_data = data;
    exp_frm  = ~stop_bit;
  endtask

  task automatic modelClear();
    exp_rdy = 1'b0;
    exp_frm = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Bit-bang one 8N1 frame with the given bit period in clocks.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int period);
    @(negedge clk);
    RX = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      repeat (period) @(negedge clk);
    end
    RX = stop_bit;
    repeat (period) @(negedge clk);
    RX = 1'b1;
    if (!stop_bit) repeat (period / 4) @(negedge clk);
  endtask

  // One-cycle acknowledge pulse followed by a full output check.
  task automatic ackPulse(input string tag);
    @(negedge clk);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    modelClear();
    checkAll(tag);
  endtask

  // Send a frame, update the model and check all outputs.
  task automatic sendAndCheck(input string tag, input logic [7:0] data, input logic stop_bit, input int period);
    applyStimulus(data, stop_bit, period);
    modelFrame(data, stop_bit);
    checkAll(tag);
  endtask

  int n;
  logic [7:0] rnd_byte;
  logic       rnd_stop;
  int         rnd_period;

  initial begin
    rst_n   = 1'b0;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    repeat (4) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // First byte: also measure pin-fall to rdy latency.
    fork
      applyStimulus(8'hA5, 1'b1, BAUD);
      begin
        @(negedge clk);
        n = 0;
        while (!rdy && n < 3 * STOP_LAT) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    checkOutput("latency", 32'(n), 32'(STOP_LAT));
    modelFrame(8'hA5, 1'b1);
    checkAll("a5");
    ackPulse("a5_ack");

    sendAndCheck("b00", 8'h00, 1'b1, BAUD);
    ackPulse("b00_ack");
    sendAndCheck("bff", 8'hFF, 1'b1, BAUD);
    ackPulse("bff_ack");

    // Short low pulse must be rejected at the start-bit check.
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD / 5) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    checkOutput("glitch.rdy", 32'(rdy), 32'(exp_rdy));
    sendAndCheck("b3c", 8'h3C, 1'b1, BAUD);
    ackPulse("b3c_ack");

    sendAndCheck("b55_frm", 8'h55, 1'b0, BAUD);
    ackPulse("b55_ack");

    sendAndCheck("b12", 8'h12, 1'b1, BAUD);
    sendAndCheck("b34_ovr", 8'h34, 1'b1, BAUD);

    // Acknowledge lands on the stop-sample edge of the third frame.
    fork
      applyStimulus(8'h56, 1'b1, BAUD);
      begin
        @(negedge clk);
        repeat (STOP_LAT - 1) @(posedge clk);
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
      end
    join
    modelClear();
    modelFrame(8'h56, 1'b1);
    checkAll("b56_same_cycle");

    // Leave a byte pending, then reset in the middle of the next frame.
    sendAndCheck("b77", 8'h77, 1'b1, BAUD);
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      RX = i[0];
      repeat (BAUD) @(negedge clk);
    end
    rst_n = 1'b0;
    RX    = 1'b1;
    exp_data = 8'h00;
    modelClear();
    @(negedge clk);
    checkAll("midreset");
    rst_n = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    checkAll("post_reset");
    sendAndCheck("bc3", 8'hC3, 1'b1, BAUD);
    ackPulse("bc3_ack");

    sendAndCheck("a5_slow", 8'hA5, 1'b1, BAUD + BAUD / 50);
    ackPulse("a5_slow_ack");
    sendAndCheck("a5_fast", 8'hA5, 1'b1, BAUD - BAUD / 50);
    ackPulse("a5_fast_ack");

    // Random bytes, stop bits, skews and acknowledge patterns.
    for (int k = 0; k < 12; k++) begin
      rnd_byte   = 8'($urandom_range(0, 255));
      rnd_stop   = ($urandom_range(0, 3) != 0);
      rnd_period = BAUD - 2 + int'($urandom_range(0, 4));
      sendAndCheck("rand", rnd_byte, rnd_stop, rnd_period);
      if ($urandom_range(0, 1) == 1) ackPulse("rand_ack");
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
